// File: rtl/pll_mon_pkg.sv
// Shared types and default configuration for the PLL frequency monitor.
// Defaults target a 79.5 MHz PLL checked against a 12 MHz / 512 reference toggle.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        WAIT_FIRST,
        MEASURE,
        STALLED
    } mon_state_e;

    localparam int unsigned DEF_CNT_W    = 16;
    localparam int unsigned DEF_EXP_MIN  = 1680;
    localparam int unsigned DEF_EXP_MAX  = 1712;
    localparam int unsigned DEF_LOCK_REQ = 4;
    localparam int unsigned DEF_TIMEOUT  = 4095;

    // PLL output = ref * (divf + 1) / 2^divq; the toggle half-period spans 2^(ref_div_log2 - 1)
    // reference cycles, so the ratio gives the expected PLL cycles per half-period.
    function automatic int unsigned expected_half_count(
        input int unsigned divf,
        input int unsigned divq,
        input int unsigned ref_div_log2
    );
        return ((divf + 1) << (ref_div_log2 - 1)) >> divq;
    endfunction

endpackage

// File: rtl/pll_freq_monitor_sync_edge_detect.sv
// Two-flop synchronizer plus a history flop; edge_pulse is high for one cycle after
// every change of async_in. Used for the reference toggle, buttons and UART lines.
module sync_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q,  hist_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        hist_d  = sync2_q;
    end

    // NOTE: non-blocking assignments keep each stage one cycle behind the previous one.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hist_q  <= hist_d;
        end
    end

    assign edge_pulse = sync2_q ^ hist_q;

endmodule

// File: rtl/pll_freq_monitor.sv
// Counts PLL clock cycles per reference half-period, judges each measurement against
// the expected window, and derives a debounced lock flag and a stall flag.
module pll_freq_monitor
    import pll_mon_pkg::*;
#(
    parameter int unsigned CNT_W    = DEF_CNT_W,
    parameter int unsigned EXP_MIN  = DEF_EXP_MIN,
    parameter int unsigned EXP_MAX  = DEF_EXP_MAX,
    parameter int unsigned LOCK_REQ = DEF_LOCK_REQ,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ref_toggle,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             in_range,
    output logic             locked,
    output logic             stalled
);

    localparam int unsigned      RUN_W     = $clog2(LOCK_REQ + 1);
    localparam logic [CNT_W-1:0] EXP_MIN_C = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] EXP_MAX_C = CNT_W'(EXP_MAX);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_MAX   = RUN_W'(LOCK_REQ);

    logic ref_edge;

    mon_state_e       state_q,      state_d;
    logic [CNT_W-1:0] counter_q,    counter_d;
    logic [CNT_W-1:0] meas_count_q, meas_count_d;
    logic             meas_valid_q, meas_valid_d;
    logic             in_range_q,   in_range_d;
    logic             locked_q,     locked_d;
    logic             stalled_q,    stalled_d;
    logic [RUN_W-1:0] run_q,        run_d;

    logic at_timeout;
    logic meas_ok;

    sync_edge_detect u_ref_sync (
        .clock      (clock),
        .reset      (reset),
        .async_in   (ref_toggle),
        .edge_pulse (ref_edge)
    );

    always_comb begin
        counter_d = counter_q;
        if (ref_edge) begin
            counter_d = CNT_W'(1);
        end else if (counter_q != TIMEOUT_C) begin
            counter_d = counter_q + CNT_W'(1);
        end
    end

    assign at_timeout = (counter_q == TIMEOUT_C);
    assign meas_ok    = (counter_q >= EXP_MIN_C) && (counter_q <= EXP_MAX_C);

    // NOTE: every signal gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_d      = state_q;
        meas_count_d = meas_count_q;
        meas_valid_d = 1'b0;
        in_range_d   = in_range_q;
        locked_d     = locked_q;
        stalled_d    = stalled_q;
        run_d        = run_q;

        unique case (state_q)
            WAIT_FIRST: begin
                if (ref_edge) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (ref_edge) begin
                    meas_count_d = counter_q;
                    meas_valid_d = 1'b1;
                    in_range_d   = meas_ok;
                    if (meas_ok) begin
                        run_d    = (run_q == RUN_MAX) ? RUN_MAX : run_q + RUN_W'(1);
                        locked_d = (run_d == RUN_MAX);
                    end else begin
                        run_d    = '0;
                        locked_d = 1'b0;
                    end
                end
            end
            STALLED: begin
                if (ref_edge) begin
                    stalled_d = 1'b0;
                    state_d   = WAIT_FIRST;
                end
            end
            default: state_d = WAIT_FIRST;
        endcase

        // A reference edge arriving on the timeout cycle wins and is measured instead.
        if (!ref_edge && at_timeout && state_q != STALLED) begin
            state_d    = STALLED;
            stalled_d  = 1'b1;
            locked_d   = 1'b0;
            in_range_d = 1'b0;
            run_d      = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= WAIT_FIRST;
            counter_q    <= '0;
            meas_count_q <= '0;
            meas_valid_q <= 1'b0;
            in_range_q   <= 1'b0;
            locked_q     <= 1'b0;
            stalled_q    <= 1'b0;
            run_q        <= '0;
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            meas_count_q <= meas_count_d;
            meas_valid_q <= meas_valid_d;
            in_range_q   <= in_range_d;
            locked_q     <= locked_d;
            stalled_q    <= stalled_d;
            run_q        <= run_d;
        end
    end

    assign meas_count = meas_count_q;
    assign meas_valid = meas_valid_q;
    assign in_range   = in_range_q;
    assign locked     = locked_q;
    assign stalled    = stalled_q;

endmodule

// File: doc/pll_freq_monitor.md
Name: pll_freq_monitor

Overview:
- Sits in the PLL output clock domain and confirms the synthesized clock runs at the intended frequency.
- Measures how many `clock` cycles fit into each half-period of a slow reference toggle. The toggle is generated in the oscillator domain (ref clock divided by 2^k).
- Reports each measurement, an in-range verdict, a debounced `locked` flag and a stall flag.
- Feeds board-level reset release and the debug LEDs/UART status.

Parameters:
- CNT_W, 16, width of the cycle counter and `meas_count`.
- EXP_MIN, 1680, lowest acceptable cycles per half-period (inclusive).
- EXP_MAX, 1712, highest acceptable cycles per half-period (inclusive). Nominal is 1696 for 79.5 MHz against 12 MHz/512.
- LOCK_REQ, 4, consecutive in-range measurements needed to assert `locked`.
- TIMEOUT, 4095, counter value at which a missing reference edge is declared a stall. Must be > EXP_MAX and < 2^CNT_W.

Ports:
- clock  in  1  PLL output clock; all logic is in this domain.
- reset  in  1  synchronous, active-high reset.
- ref_toggle  in  1  asynchronous square wave from the reference domain; each edge (rise or fall) marks one half-period.
- meas_count  out  CNT_W  last completed measurement in clock cycles.
- meas_valid  out  1  one-cycle pulse when `meas_count` updates.
- in_range  out  1  verdict for the last measurement: EXP_MIN <= meas_count <= EXP_MAX.
- locked  out  1  asserted after LOCK_REQ consecutive in-range measurements.
- stalled  out  1  no reference edge seen for TIMEOUT cycles.

Behaviour:
- Reset values: meas_count=0, meas_valid=0, in_range=0, locked=0, stalled=0, counter=0, good-run count=0, state=WAIT_FIRST. The synchronizer flops and the edge-history flop are also cleared to 0.
- Input path: two-flop synchronizer on `ref_toggle`, then a third flop for edge history. `edge` = sync2 XOR hist. Delay from the input change to `edge` is a fixed 3 cycles. The delay is constant, so measurements are unaffected.
- Counter semantics: on an `edge` cycle the counter loads 1; otherwise it increments, saturating at TIMEOUT. If `edge` pulses at cycles t0 and t1, the measurement is t1 - t0.
- FSM states:
  - WAIT_FIRST: the counter still runs. On `edge` go to MEASURE with no report, because the first window is partial. If counter == TIMEOUT, go to STALLED.
  - MEASURE, on `edge`: meas_count <= counter; meas_valid pulses the next cycle together with the updated meas_count and in_range; in_range is computed from the latched value.
    - In range: good-run count increments, saturating at LOCK_REQ; `locked` sets the cycle the run reaches LOCK_REQ.
    - Out of range: good-run count=0 and `locked`=0 in the same update.
  - MEASURE, when counter reaches TIMEOUT with no edge: go to STALLED.
  - STALLED: stalled=1, locked=0, in_range=0, good-run count=0; meas_count holds its old value and no meas_valid is issued. On `edge`: stalled=0, go to WAIT_FIRST, which discards the next partial window; the counter loads 1.
- Boundary rules:
  - Simultaneous `edge` and counter==TIMEOUT: `edge` wins; the measurement is TIMEOUT, which is out of range, so no stall is declared.
  - meas_valid lasts exactly one cycle, and there is at most one per edge.
  - Reset mid-measurement: all state clears and the next edge is treated as a first edge.
  - All outputs are registered; there are no combinational paths from ref_toggle.
- Comparisons are unsigned, at CNT_W bits.

Decomposition:
- Shared package `pll_mon_pkg`:
  - FSM state enum {WAIT_FIRST, MEASURE, STALLED}.
  - Default constants for the nominal 79.5 MHz/12 MHz configuration (EXP_MIN, EXP_MAX, LOCK_REQ, TIMEOUT).
  - A function deriving the expected count from PLL DIVF/DIVQ and the reference divider.
- One sub-module: `sync_edge_detect` (2-flop synchronizer + history flop + XOR edge pulse). It is reused elsewhere for async button and UART-line inputs.

Test Plan:
- Bench drives ref_toggle synchronously with a half-period of 1696 clocks for 6 edges. Required: the first edge produces no meas_valid; the next 5 edges each give meas_valid with meas_count=1696 and in_range=1; locked rises with the 4th valid measurement and stays 1.
- Locked state, then one half-period of 1750. Required: meas_count=1750, in_range=0, locked drops in the same cycle as that meas_valid. Four further 1696 periods are needed to relock.
- Boundaries: half-periods of 1680, 1712, 1679 and 1713. Required: in_range = 1, 1, 0, 0 respectively.
- Hold ref_toggle constant after lock. Required: stalled=1 and locked=0 exactly TIMEOUT cycles after the last edge; no meas_valid. Then resume the 1696 toggle: stalled clears on the first edge, the first window is discarded, and the next valid measurement is 1696.
- Assert reset for 1 cycle midway through a locked window. Required: all outputs are 0 the cycle after reset; the next edge is not reported; relock needs 4 further good periods.
- Drive an edge exactly when the counter reaches TIMEOUT (half-period 4095). Required: meas_valid with meas_count=4095, in_range=0, stalled stays 0.
